// File: rtl/context_operand_feeder.sv
// Buffers operand pairs, holds each on A/B for HOLD cycles, then captures XOUT as a result.
// Latency HOLD+1 cycles from accept to OUT_VALID; IN_READY drops only when the FIFO is full, OUT_VALID holds until OUT_READY.
module context_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 27
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [7:0]             IN_A,
  input  logic [7:0]             IN_B,
  output logic [7:0]             A,
  output logic [7:0]             B,
  input  logic [7:0]             XOUT,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [7:0]             OUT_DATA,
  output logic                   OUT_DZ,
  output logic [$clog2(DEPTH):0] COUNT
);
  localparam int PW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD - 1);
  localparam logic [HW-1:0] ONE_HLD  = HW'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT} state_t;

  typedef struct packed {
    logic       dz;
    logic [7:0] a;
    logic [7:0] b;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        in_ent;
  entry_t        head;
  logic          in_dz;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

  state_t        state_q;
  logic [HW-1:0] hold_q;
  logic [7:0]    a_q, b_q, out_dat_q;
  logic          dz_q, out_vld_q, out_dz_q;

  // A zero divisor is replaced by 1 at the FIFO input so B never reaches the datapath as 0.
  assign in_dz  = (IN_B == 8'd0);
  assign in_ent = {in_dz, IN_A, (in_dz ? 8'd1 : IN_B)};
  assign head   = mem_q[rd_ptr_q];

  assign IN_READY = (count_q < FULL_CNT);
  assign push     = IN_VALID && IN_READY;
  assign pop      = (count_q != '0) &&
                    ((state_q == IDLE) || ((state_q == EMIT) && OUT_READY));

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + ONE_CNT;
    else if (!push && pop)
      count_d = count_q - ONE_CNT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
      if (pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= in_ent;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      a_q       <= 8'd0;
      b_q       <= 8'd1;
      dz_q      <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= 8'd0;
      out_dz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            a_q     <= head.a;
            b_q     <= head.b;
            dz_q    <= head.dz;
            hold_q  <= HOLD_LD;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_q == '0) begin
            out_dat_q <= XOUT;
            out_dz_q  <= dz_q;
            out_vld_q <= 1'b1;
            state_q   <= EMIT;
          end else begin
            hold_q <= hold_q - ONE_HLD;
          end
        end
        EMIT: begin
          if (OUT_READY) begin
            out_vld_q <= 1'b0;
            if (count_q != '0) begin
              a_q     <= head.a;
              b_q     <= head.b;
              dz_q    <= head.dz;
              hold_q  <= HOLD_LD;
              state_q <= DRIVE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign OUT_VALID = out_vld_q;
  assign OUT_DATA  = out_dat_q;
  assign OUT_DZ    = out_dz_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_context_operand_feeder.sv
// Bench for context_operand_feeder: table of single pairs plus backpressure, overlap and reset sequences.
module tb_context_operand_feeder;
  localparam int DEPTH = 4;
  localparam int HOLD  = 3;

  logic       CLK = 1'b0;
  logic       RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_DZ;
  logic [7:0] IN_A, IN_B, A, B, XOUT, OUT_DATA;
  logic [2:0] COUNT;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [8:0] sb [$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] x;
    logic       dz;
  } vec_t;

  function automatic logic [7:0] ref_x(input logic [7:0] a, input logic [7:0] b);
    return (a - b) + (a * b);
  endfunction

  assign XOUT = ref_x(A, B);

  context_operand_feeder #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .A(A), .B(B), .XOUT(XOUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_DZ(OUT_DZ), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: samples 2 time units before each rising edge, when all inputs are settled.
  always begin
    logic [8:0] e;
    @(negedge CLK);
    #3;
    if (RST) begin
      sb.delete();
    end else begin
      if (IN_VALID && IN_READY)
        sb.push_back({IN_B == 8'd0, ref_x(IN_A, (IN_B == 8'd0) ? 8'd1 : IN_B)});
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", OUT_DATA, e[7:0]);
          chk("sb_dz", OUT_DZ, e[8]);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, output int t_acc);
    int guard;
    guard = 0;
    IN_VALID = 1'b1;
    IN_A = a;
    IN_B = b;
    while (!IN_READY && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (!IN_READY) chk("in_ready_timeout", 0, 1);
    @(posedge CLK); #1;
    t_acc = cyc;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_out(output int t_v);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!OUT_VALID && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (!OUT_VALID) chk("out_valid_timeout", 0, 1);
    t_v = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int t_acc, t_v, t_prev, acc, seen, guard;
    logic [7:0] d0;
    logic [7:0] ea, eb;

    vecs[0] = '{a: 8'd20,  b: 8'd5,   x: 8'd115, dz: 1'b0};
    vecs[1] = '{a: 8'd7,   b: 8'd0,   x: 8'd13,  dz: 1'b1};
    vecs[2] = '{a: 8'd200, b: 8'd3,   x: 8'd29,  dz: 1'b0};
    vecs[3] = '{a: 8'd0,   b: 8'd0,   x: 8'd255, dz: 1'b1};
    vecs[4] = '{a: 8'd255, b: 8'd255, x: 8'd1,   dz: 1'b0};
    vecs[5] = '{a: 8'd16,  b: 8'd16,  x: 8'd0,   dz: 1'b0};
    vecs[6] = '{a: 8'd3,   b: 8'd200, x: 8'd147, dz: 1'b0};
    vecs[7] = '{a: 8'd128, b: 8'd2,   x: 8'd126, dz: 1'b0};

    RST = 1'b1; IN_VALID = 1'b0; IN_A = 8'd0; IN_B = 8'd0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_A", A, 0);
    chk("rst_B", B, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_out_dz", OUT_DZ, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_in_ready", IN_READY, 1);

    // Table: one pair at a time into an idle block
    for (int i = 0; i < 8; i++) begin
      ea = vecs[i].a;
      eb = vecs[i].dz ? 8'd1 : vecs[i].b;
      send(vecs[i].a, vecs[i].b, t_acc);
      @(posedge CLK); #1;
      chk("vec_A_drive", A, ea);
      chk("vec_B_drive", B, eb);
      wait_out(t_v);
      chk("vec_latency", t_v - t_acc, HOLD + 1);
      chk("vec_data", OUT_DATA, vecs[i].x);
      chk("vec_dz", OUT_DZ, vecs[i].dz);
      @(posedge CLK); #1;
      chk("vec_idle_valid", OUT_VALID, 0);
      chk("vec_idle_count", COUNT, 0);
    end

    // Full FIFO under backpressure, then drain
    OUT_READY = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      IN_VALID = 1'b1;
      IN_A = 8'(10 + i * 37);
      IN_B = 8'(i * 3);
      if (IN_READY) acc++;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_in_ready", IN_READY, 0);
    chk("bp_count", COUNT, 4);
    wait_out(t_v);
    d0 = OUT_DATA;
    chk("bp_first_data", d0, ref_x(8'd10, 8'd1));
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_valid_held", OUT_VALID, 1);
      chk("bp_data_stable", OUT_DATA, d0);
    end
    #1 OUT_READY = 1'b1;
    t_prev = cyc;
    @(posedge CLK); #1;
    for (int k = 1; k < 5; k++) begin
      wait_out(t_v);
      chk("bp_spacing", t_v - t_prev, HOLD + 1);
      t_prev = t_v;
      @(posedge CLK); #1;
    end
    chk("bp_drained", sb.size(), 0);
    chk("bp_drained_valid", OUT_VALID, 0);

    // Push on the same edge as the EMIT-to-DRIVE pop, across pointer wrap
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1;
      IN_A = 8'(50 + i);
      IN_B = 8'(9 * i);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    chk("pp_count_init", COUNT, 2);
    for (int j = 0; j < 10; j++) begin
      wait_out(t_v);
      #1;
      chk("pp_in_ready", IN_READY, 1);
      IN_VALID = 1'b1;
      IN_A = 8'(j * 29 + 1);
      IN_B = 8'((j % 3 == 0) ? 0 : j * 11);
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      chk("pp_count_steady", COUNT, 2);
    end
    OUT_READY = 1'b1;
    guard = 0;
    while (!(sb.size() == 0 && !OUT_VALID && COUNT == 0) && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk("pp_drain_done", (sb.size() == 0 && !OUT_VALID && COUNT == 0), 1);

    // Reset while DRIVE with three pairs buffered
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1;
      IN_A = 8'(90 + i);
      IN_B = 8'(i + 4);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    chk("rd_count_before", COUNT, 3);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rd_A", A, 0);
    chk("rd_B", B, 1);
    chk("rd_out_valid", OUT_VALID, 0);
    chk("rd_out_data", OUT_DATA, 0);
    chk("rd_out_dz", OUT_DZ, 0);
    chk("rd_count", COUNT, 0);
    chk("rd_in_ready", IN_READY, 1);
    seen = 0;
    repeat (HOLD + 4) begin
      @(negedge CLK);
      if (OUT_VALID) seen++;
    end
    chk("rd_no_result", seen, 0);
    #1;
    send(8'd20, 8'd5, t_acc);
    wait_out(t_v);
    chk("rd_after_latency", t_v - t_acc, HOLD + 1);
    chk("rd_after_data", OUT_DATA, 115);
    @(posedge CLK); #1;
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
